// File: rtl/cruce_semaforos_ctrl.sv
// Two-way intersection sequencer: NS/EO lamps, pedestrian phase and night flashing.
// Prescaler yields a one-cycle tick; a Moore FSM with registered lamp outputs.
module cruce_semaforos_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int T_VERDE      = 5,
    parameter int T_AMARILLO   = 2,
    parameter int T_TODOS_ROJO = 1,
    parameter int T_PEATON     = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_peaton,
    input  logic       modo_noche,
    output logic       ns_rojo,
    output logic       ns_amarillo,
    output logic       ns_verde,
    output logic       eo_rojo,
    output logic       eo_amarillo,
    output logic       eo_verde,
    output logic       peaton_pasa,
    output logic       peaton_espera,
    output logic [2:0] estado,
    output logic       tick
);

    typedef enum logic [2:0] {
        ROJO_1      = 3'd0,
        NS_VERDE    = 3'd1,
        NS_AMARILLO = 3'd2,
        ROJO_2      = 3'd3,
        EO_VERDE    = 3'd4,
        EO_AMARILLO = 3'd5,
        PEATON      = 3'd6,
        NOCHE       = 3'd7
    } estado_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]    presc;
    logic             tick_i;
    estado_t          st, nxt;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             flash, flash_n;
    logic             sig_eo, sig_n;

    assign tick_i = (presc == PW'(TICK_DIV - 1));
    assign tick   = tick_i;
    assign estado = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (tick_i)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    function automatic logic [CNT_W-1:0] fin(estado_t s);
        case (s)
            NS_VERDE, EO_VERDE:       return CNT_W'(T_VERDE - 1);
            NS_AMARILLO, EO_AMARILLO: return CNT_W'(T_AMARILLO - 1);
            ROJO_1, ROJO_2:           return CNT_W'(T_TODOS_ROJO - 1);
            PEATON:                   return CNT_W'(T_PEATON - 1);
            default:                  return '0;
        endcase
    endfunction

    always_comb begin
        nxt     = st;
        cnt_n   = cnt;
        flash_n = flash;
        sig_n   = sig_eo;
        if (tick_i) begin
            if (st == NOCHE) begin
                if (!modo_noche) begin
                    nxt   = ROJO_1;
                    cnt_n = '0;
                end else begin
                    flash_n = ~flash;
                end
            end else if (cnt == fin(st)) begin
                cnt_n = '0;
                unique case (st)
                    ROJO_1: begin
                        if (modo_noche) begin
                            nxt     = NOCHE;
                            flash_n = 1'b1;
                        end else if (peaton_espera) begin
                            nxt   = PEATON;
                            sig_n = 1'b0;
                        end else begin
                            nxt = NS_VERDE;
                        end
                    end
                    ROJO_2: begin
                        if (modo_noche) begin
                            nxt     = NOCHE;
                            flash_n = 1'b1;
                        end else if (peaton_espera) begin
                            nxt   = PEATON;
                            sig_n = 1'b1;
                        end else begin
                            nxt = EO_VERDE;
                        end
                    end
                    NS_VERDE:    nxt = NS_AMARILLO;
                    NS_AMARILLO: nxt = ROJO_2;
                    EO_VERDE:    nxt = EO_AMARILLO;
                    EO_AMARILLO: nxt = ROJO_1;
                    PEATON:      nxt = sig_eo ? EO_VERDE : NS_VERDE;
                    default:     nxt = st;
                endcase
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    // Lamps decode the next state so they switch in the same cycle as estado.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= ROJO_1;
            cnt           <= '0;
            flash         <= 1'b0;
            sig_eo        <= 1'b0;
            peaton_espera <= 1'b0;
            ns_rojo       <= 1'b1;
            ns_amarillo   <= 1'b0;
            ns_verde      <= 1'b0;
            eo_rojo       <= 1'b1;
            eo_amarillo   <= 1'b0;
            eo_verde      <= 1'b0;
            peaton_pasa   <= 1'b0;
        end else begin
            st     <= nxt;
            cnt    <= cnt_n;
            flash  <= flash_n;
            sig_eo <= sig_n;
            if (nxt == PEATON && st != PEATON)
                peaton_espera <= 1'b0;
            else if (btn_peaton)
                peaton_espera <= 1'b1;
            ns_rojo     <= !(nxt inside {NS_VERDE, NS_AMARILLO, NOCHE});
            ns_amarillo <= (nxt == NS_AMARILLO) || (nxt == NOCHE && flash_n);
            ns_verde    <= (nxt == NS_VERDE);
            eo_rojo     <= !(nxt inside {EO_VERDE, EO_AMARILLO, NOCHE});
            eo_amarillo <= (nxt == EO_AMARILLO) || (nxt == NOCHE && flash_n);
            eo_verde    <= (nxt == EO_VERDE);
            peaton_pasa <= (nxt == PEATON);
        end
    end

endmodule

// File: tb/tb_cruce_semaforos_ctrl.sv
// Directed bench for cruce_semaforos_ctrl: fast instance (TICK_DIV=1)
// and a slow instance (TICK_DIV=4) sharing clock, reset and inputs.
module tb_cruce_semaforos_ctrl;

    logic clk = 1'b0;
    logic rst_n, btn, modo;

    logic ns_r, ns_a, ns_v, eo_r, eo_a, eo_v, pasa, espera, tk;
    logic [2:0] est;
    logic b_ns_r, b_ns_a, b_ns_v, b_eo_r, b_eo_a, b_eo_v, b_pasa, b_espera, b_tk;
    logic [2:0] b_est;

    int errs = 0;
    int checks = 0;
    int q[$];
    int pat[16] = '{0, 1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5};

    always #5 clk = ~clk;

    cruce_semaforos_ctrl #(
        .TICK_DIV(1), .T_VERDE(5), .T_AMARILLO(2),
        .T_TODOS_ROJO(1), .T_PEATON(3), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_peaton(btn), .modo_noche(modo),
        .ns_rojo(ns_r), .ns_amarillo(ns_a), .ns_verde(ns_v),
        .eo_rojo(eo_r), .eo_amarillo(eo_a), .eo_verde(eo_v),
        .peaton_pasa(pasa), .peaton_espera(espera),
        .estado(est), .tick(tk)
    );

    cruce_semaforos_ctrl #(
        .TICK_DIV(4), .T_VERDE(5), .T_AMARILLO(2),
        .T_TODOS_ROJO(1), .T_PEATON(3), .CNT_W(8)
    ) dut_lento (
        .clk(clk), .rst_n(rst_n), .btn_peaton(btn), .modo_noche(modo),
        .ns_rojo(b_ns_r), .ns_amarillo(b_ns_a), .ns_verde(b_ns_v),
        .eo_rojo(b_eo_r), .eo_amarillo(b_eo_a), .eo_verde(b_eo_v),
        .peaton_pasa(b_pasa), .peaton_espera(b_espera),
        .estado(b_est), .tick(b_tk)
    );

    logic [6:0] lamps, b_lamps;
    assign lamps   = {ns_r, ns_a, ns_v, eo_r, eo_a, eo_v, pasa};
    assign b_lamps = {b_ns_r, b_ns_a, b_ns_v, b_eo_r, b_eo_a, b_eo_v, b_pasa};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // {ns_r, ns_a, ns_v, eo_r, eo_a, eo_v, pasa} per state (NOCHE handled apart)
    function automatic logic [6:0] exp_lamps(int s);
        case (s)
            0, 3:    return 7'b1001000;
            1:       return 7'b0011000;
            2:       return 7'b0101000;
            4:       return 7'b1000010;
            5:       return 7'b1000100;
            6:       return 7'b1001001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(int s, int n);
        for (int i = 0; i < n; i++) q.push_back(s);
    endtask

    task automatic check_state(string tag, int s);
        chk({tag, "_estado"}, 32'(est), 32'(s));
        if (s != 7) chk({tag, "_lamps"}, 32'(lamps), 32'(exp_lamps(s)));
    endtask

    task automatic do_reset();
        btn   = 1'b0;
        modo  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Both instances, every cycle out of reset (amber pair in NOCHE is by design)
    always @(negedge clk) begin
        if (rst_n) begin
            if (est != 3'd7)
                chk("safety", 32'((ns_v | ns_a) & (eo_v | eo_a)), 0);
            chk("walk_red", 32'(pasa & !(ns_r & eo_r)), 0);
            chk("b_safety", 32'((b_ns_v | b_ns_a) & (b_eo_v | b_eo_a)), 0);
        end
    end

    initial begin
        // Reset state
        btn   = 1'b0;
        modo  = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_estado", 32'(est), 0);
        chk("rst_lamps", 32'(lamps), 32'(7'b1001000));
        chk("rst_espera", 32'(espera), 0);
        chk("rst_tick_fast", 32'(tk), 1);
        chk("rst_tick_slow", 32'(b_tk), 0);
        chk("rst_b_lamps", 32'(b_lamps), 32'(7'b1001000));

        // 1 and 5: free-running cycle, slow instance at quarter rate
        do_reset();
        for (int k = 0; k < 64; k++) begin
            if (k > 0) step();
            if (k < 48) check_state("s1", pat[k % 16]);
            chk("s5_estado", 32'(b_est), 32'(pat[(k / 4) % 16]));
            chk("s5_lamps", 32'(b_lamps), 32'(exp_lamps(pat[(k / 4) % 16])));
            chk("s5_tick", 32'(b_tk), 32'((k % 4) == 3));
        end

        // 2: single button pulse during NS_VERDE
        do_reset();
        q.delete();
        add(0, 1); add(1, 5); add(2, 2); add(3, 1); add(6, 3);
        add(4, 5); add(5, 2); add(0, 1); add(1, 1);
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) step();
            check_state("s2", q[k]);
            chk("s2_espera", 32'(espera), 32'(k >= 3 && k <= 8));
            btn = (k == 2);
        end

        // 3: button held; first ROJO_1 exit sees no latched request yet
        do_reset();
        btn = 1'b1;
        q.delete();
        add(0, 1); add(1, 5); add(2, 2); add(3, 1); add(6, 3);
        add(4, 5); add(5, 2); add(0, 1); add(6, 3); add(1, 5);
        add(2, 2); add(3, 1); add(6, 3); add(4, 1);
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) step();
            check_state("s3", q[k]);
            chk("s3_espera", 32'(espera),
                32'(!(k == 0 || k == 9 || k == 20 || k == 31)));
        end
        btn = 1'b0;

        // 4: night mode requested during EO_VERDE
        do_reset();
        for (int k = 0; k < 24; k++) begin
            if (k > 0) step();
            if (k < 16) check_state("s4", pat[k]);
            else if (k == 16 || k == 21) check_state("s4", 0);
            else if (k >= 22) check_state("s4", 1);
            else begin
                check_state("s4", 7);
                chk("s4_noche_lamps", 32'(lamps),
                    32'((k % 2) ? 7'b0100100 : 7'b0000000));
            end
            if (k == 10) modo = 1'b1;
            if (k == 20) modo = 1'b0;
        end

        // 6: asynchronous reset mid-EO_AMARILLO with a request pending
        do_reset();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step();
            check_state("s6", pat[k]);
            btn = (k == 10);
        end
        chk("s6_pend", 32'(espera), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_estado", 32'(est), 0);
        chk("s6_async_lamps", 32'(lamps), 32'(7'b1001000));
        chk("s6_async_espera", 32'(espera), 0);
        chk("s6_async_b_lamps", 32'(b_lamps), 32'(7'b1001000));
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) step();
            check_state("s6_restart", pat[k % 16]);
            chk("s6_restart_espera", 32'(espera), 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cruce_semaforos_ctrl.md
Name: cruce_semaforos_ctrl

Overview:
Sequencer for a two-way intersection: north-south (NS) and east-west (EO) vehicle lights plus a pedestrian crossing. An internal prescaler derives a one-cycle "second" tick from the board clock. A Moore FSM walks green → amber → all-red for each direction in turn. It also serves latched pedestrian requests and provides a night mode with flashing amber. This block sits above the single-light traffic FSM and drives the lamp outputs of both directions directly.

Parameters:
TICK_DIV, 50000000, clock cycles per logical second; 1 means a tick every cycle (simulation).
T_VERDE, 5, green duration in ticks (≥1).
T_AMARILLO, 2, amber duration in ticks (≥1).
T_TODOS_ROJO, 1, all-red clearance duration in ticks (≥1).
T_PEATON, 4, pedestrian walk duration in ticks (≥1).
CNT_W, 8, width of the phase counter; every T_* must be < 2^CNT_W.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
btn_peaton  in  1  pedestrian request, synchronous level, sampled every clock
modo_noche  in  1  night-mode request, synchronous level
ns_rojo  out  1  NS red lamp
ns_amarillo  out  1  NS amber lamp
ns_verde  out  1  NS green lamp
eo_rojo  out  1  EO red lamp
eo_amarillo  out  1  EO amber lamp
eo_verde  out  1  EO green lamp
peaton_pasa  out  1  pedestrian walk lamp
peaton_espera  out  1  pedestrian request pending
estado  out  3  current FSM state code (debug)
tick  out  1  one-cycle second pulse (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Prescaler: counter 0..TICK_DIV-1, wraps; tick=1 in the cycle where counter==TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- State codes: ROJO_1=0, NS_VERDE=1, NS_AMARILLO=2, ROJO_2=3, EO_VERDE=4, EO_AMARILLO=5, PEATON=6, NOCHE=7.
- Reset values: estado=ROJO_1; phase counter=0; prescaler=0; ns_rojo=eo_rojo=1; all other lamps 0; peaton_espera=0; flash bit=0; siguiente_eo=0.
- Outputs are registered, a pure function of state, and change in the same cycle estado changes. No combinational input→output path.
- Phase timing: on each tick, if phase counter == T_state-1, take the transition and clear the counter; otherwise increment. Each timed state therefore lasts exactly T_state ticks. No counter activity without a tick.
- Transitions:
  - ROJO_1 ends → NOCHE if modo_noche; else PEATON (siguiente_eo=0) if pending; else NS_VERDE.
  - NS_VERDE → NS_AMARILLO → ROJO_2.
  - ROJO_2 ends → NOCHE if modo_noche; else PEATON (siguiente_eo=1) if pending; else EO_VERDE.
  - EO_VERDE → EO_AMARILLO → ROJO_1.
  - PEATON ends → EO_VERDE if siguiente_eo, else NS_VERDE.
  - NOCHE: at each tick, if modo_noche==0 → ROJO_1 (counter 0); otherwise toggle flash.
- Priority at all-red exit: night over pedestrian over normal. A pending request is kept across NOCHE.
- Lamp decode:
  - Red lamp of a direction = 1 in every state except its own green/amber and NOCHE.
  - Green/amber lamp = 1 only in the matching state.
  - PEATON: both reds = 1, peaton_pasa=1.
  - NOCHE: all reds 0, greens 0, ns_amarillo=eo_amarillo=flash. flash is set to 1 on entry to NOCHE.
- Safety invariant: never any cycle where ns_verde|ns_amarillo and eo_verde|eo_amarillo are both 1. peaton_pasa=1 implies ns_rojo=eo_rojo=1.
- Pending latch:
  - Set in any cycle with btn_peaton=1.
  - Cleared in the cycle the FSM enters PEATON; clear wins over set in that cycle.
  - A button still held in the next cycle re-arms it.
  - A request raised during PEATON is served at the next all-red.
- modo_noche is evaluated only at all-red exits; it does not cut green or amber short.
- Reset mid-operation: immediate return to reset values regardless of state or pending request.

Test Plan:
All scenarios use TICK_DIV=1, T_VERDE=5, T_AMARILLO=2, T_TODOS_ROJO=1, T_PEATON=3, unless stated.
1. Release rst_n, no inputs → ROJO_1 for 1 clock, then ns_verde 5 clocks, ns_amarillo 2, all-red 1, eo_verde 5, eo_amarillo 2. Period is 16 clocks, repeated ≥3 times; safety invariant checked every cycle.
2. Pulse btn_peaton 1 cycle during NS_VERDE → peaton_espera=1 next cycle. At ROJO_2 exit: estado=6, peaton_pasa=1 for 3 clocks, peaton_espera cleared on entry, then EO_VERDE.
3. Hold btn_peaton high continuously → PEATON inserted at every all-red exit. Order: ROJO_1,PEATON,NS_VERDE,…,ROJO_2,PEATON,EO_VERDE; peaton_espera re-asserts the cycle after PEATON entry.
4. Assert modo_noche during EO_VERDE → green/amber complete normally, then NOCHE at the ROJO_1 exit. ambers toggle 1,0,1,… every clock, reds 0. Deassert → next tick ROJO_1 for 1 clock, then NS_VERDE.
5. With TICK_DIV=4 → tick every 4th clock; ns_verde lasts 20 clocks, amber 8, all-red 4.
6. Drop rst_n asynchronously mid-EO_AMARILLO with a request pending → outputs go to reset values immediately, without waiting for a clock edge. peaton_espera=0; on release the sequence restarts exactly as in scenario 1.
